// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I main control FSM.
// Holds opcode constants, the FSM state encoding, the opcode classes
// produced by the instruction decoder, and the mux/ALUOp select codes.
package multicycle_controller_pkg;

  // Supported major opcodes (IR[6:0]).
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // FSM states, 4-bit binary encoding.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  // Instruction class as seen by the DECODE step.
  typedef enum logic [2:0] {
    CLS_LOAD    = 3'd0,
    CLS_STORE   = 3'd1,
    CLS_R       = 3'd2,
    CLS_I       = 3'd3,
    CLS_BEQ     = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  // ALUOp towards the downstream ALU control decode.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Result mux.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate formats.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_decoder.sv
// mc_instr_decoder: purely combinational opcode decode.
// Ports:
//   op       in  7  opcode field from IR
//   imm_src  out 2  immediate format for the immediate generator
//   op_class out    instruction class used by the DECODE step
//   illegal  out 1  opcode is not one of the supported instructions
module mc_instr_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src,
  output op_class_t  op_class,
  output logic       illegal
);

  always_comb begin
    // NOTE: defaults first keep every path fully assigned, so no latch is inferred.
    imm_src  = IMM_I;
    op_class = CLS_ILLEGAL;
    illegal  = 1'b0;
    case (op)
      OP_LW:  op_class = CLS_LOAD;
      OP_SW:  begin op_class = CLS_STORE; imm_src = IMM_S; end
      OP_R:   op_class = CLS_R;
      OP_I:   op_class = CLS_I;
      OP_BEQ: begin op_class = CLS_BEQ;   imm_src = IMM_B; end
      OP_JAL: begin op_class = CLS_JAL;   imm_src = IMM_J; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multi-cycle RV32I core.
// Steps the shared ALU, unified memory port, IR and register file through
// fetch/decode/execute/memory/writeback. Emits ALUOp only; ALUControl is
// produced by the downstream ALU control decode.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op, zero, mem_ready opcode from IR, ALU zero flag, memory handshake
//   mem_req, MemWrite, AdrSrc                 memory port control
//   PCWrite, IRWrite, RegWrite                state-element write enables
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc datapath selects
//   instr_done          pulse on the last cycle of each instruction
//   illegal_instr       unsupported opcode reached
// Parameter ILLEGAL_HALT: 1 parks in ILLEGAL until reset, 0 flags for one
// cycle and resumes fetching (the bad instruction is skipped).
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       illegal_instr
);

  state_t    state_q, state_d;
  op_class_t op_class;
  logic      dec_illegal;

  // Raw strobes before reset gating.
  logic mem_req_r, pc_write_r, mem_write_r, ir_write_r;
  logic reg_write_r, done_r, illegal_r;

  mc_instr_decoder u_decoder (
    .op       (op),
    .imm_src  (ImmSrc),
    .op_class (op_class),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_r   = 1'b0;
    pc_write_r  = 1'b0;
    mem_write_r = 1'b0;
    ir_write_r  = 1'b0;
    reg_write_r = 1'b0;
    done_r      = 1'b0;
    illegal_r   = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed while the instruction is read; both land together.
        mem_req_r  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        ir_write_r = mem_ready;
        pc_write_r = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target OldPC+imm is precomputed here for BEQ.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (dec_illegal) state_d = S_ILLEGAL;
        else begin
          case (op_class)
            CLS_LOAD, CLS_STORE: state_d = S_MEMADR;
            CLS_R:               state_d = S_EXECR;
            CLS_I:               state_d = S_EXECI;
            CLS_BEQ:             state_d = S_BEQ;
            CLS_JAL:             state_d = S_JAL;
            default:             state_d = S_ILLEGAL;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op_class == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_r = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        // Strobe is held for the whole handshake, not just the final cycle.
        mem_req_r   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_r = 1'b1;
        done_r      = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_r = 1'b1;
        done_r      = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_r = 1'b1;
        done_r      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        // ALUOut still holds the target from DECODE; the ALU compares rs1-rs2.
        ALUSrcA    = SRCA_RS1;
        ALUOp      = ALUOP_SUB;
        pc_write_r = zero;
        done_r     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write_r = 1'b1;
        state_d    = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal_r = 1'b1;
        if (!ILLEGAL_HALT) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces FETCH asynchronously, but FETCH itself requests memory and
  // may write PC/IR; gating with rst_n keeps all strobes quiet during reset.
  assign mem_req       = mem_req_r   & rst_n;
  assign PCWrite       = pc_write_r  & rst_n;
  assign MemWrite      = mem_write_r & rst_n;
  assign IRWrite       = ir_write_r  & rst_n;
  assign RegWrite      = reg_write_r & rst_n;
  assign instr_done    = done_r      & rst_n;
  assign illegal_instr = illegal_r   & rst_n;

endmodule
